uart_char_rx: RTL and testbench
===============================

# uart_char_rx

Serial character receiver that sits directly upstream of the `num` ASCII case-conversion stage. It deserialises an 8N1 asynchronous bit stream (start bit, 8 data bits LSB first, 1 stop bit) into a parallel character. Each character is presented with a valid/ready handshake: `char_out[7]` drives `num` input A and `char_out[0]` drives input H. Framing errors and overruns are flagged so that corrupted characters never reach the converter.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit (N); legal values are even, ≥ 4.
- `clk` input 1: single clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_in` input 1: asynchronous serial line; idle level is 1.
- `char_out` output 8: received character, MSB = bit 7 (maps to A); reset value 8'h00.
- `char_valid` output 1: `char_out` holds an unconsumed character; reset value 0.
- `char_ready` input 1: the downstream stage accepts the character when `char_valid && char_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0; reset value 0.
- `overrun_err` output 1: one-cycle pulse when a character is dropped; reset value 0.

## Operation
- **Synchroniser.** `rx_in` passes through two flops, giving `rx_s`. Both flops reset to 1. The FSM sees only `rx_s`.
- **Constants.** H = N/2. `cnt` is a bit-timer counter wide enough to hold N−1. `bitn` is a 3-bit counter of data bits. `shreg` is an 8-bit shift register.
- **IDLE.** If `rx_s` == 0: go to START and set `cnt` = 0.
- **START.** `cnt` increments each cycle. At `cnt` == H−1, sample `rx_s`:
  - 0: go to DATA with `cnt` = 0 and `bitn` = 0.
  - 1: the low level was a glitch; return to IDLE with no flags raised.
- **DATA.** At `cnt` == N−1:
  - Shift right, `shreg` = {`rx_s`, `shreg`[7:1]}.
  - Set `cnt` = 0.
  - If `bitn` == 7, go to STOP; otherwise increment `bitn`.
- **STOP.** At `cnt` == N−1, sample `rx_s`:
  - 1 with the output slot free (`char_valid` == 0, or being accepted in this same cycle): load `char_out` = `shreg`, set `char_valid` = 1, go to IDLE.
  - 1 with the output slot occupied: pulse `overrun_err`. The new character is discarded and the held `char_out` is unchanged. Go to IDLE.
  - 0: pulse `frame_err`, discard `shreg`, go to BREAK.
- **BREAK.** Wait for `rx_s` == 1, then go to IDLE. This blocks false start detection during a held-low line.
- **Handshake.**
  - `char_valid` clears on the edge after a cycle with `char_valid && char_ready`.
  - `char_out` is stable while `char_valid` == 1.
  - `char_ready` is ignored while `char_valid` == 0.
- **Simultaneous accept and load.** Accept and load in the same cycle means `char_valid` stays 1 with the new data, and no overrun is raised.
- **Reset.** Reset mid-frame sets the FSM to IDLE and clears `cnt`, `bitn`, `shreg`, `char_out`, `char_valid` and both error outputs on the next edge. The partial character is lost. After reset, reception restarts only on a new 1→0 transition of `rx_s`.
- The block holds no character data other than `shreg` and the single output register. It has no FIFO.

## Timing
- Let E0 be the edge at which the first synchroniser flop first captures `rx_in` = 0.
  - The FSM enters START at edge E0+2.
  - The start bit is validated at edge E0+2+H.
  - Data bit k is sampled at edge E0+2+H+(k+1)·N.
  - The stop bit is sampled at edge E0+2+H+9N.
- `char_valid`, `frame_err` or `overrun_err` is registered at the stop-sample edge (E0+2+H+9N). With N = 16 that is E0+154.
- Back-to-back frames are supported:
  - IDLE is re-entered at the stop-sample edge.
  - A start bit whose falling edge follows the stop bit by 0 idle bit-times is detected.
- `frame_err` and `overrun_err` are high for exactly one cycle each per event.

## Test plan
- **Single character.** N = 16, `char_ready` tied 1, send 0x61 ('a').
  - `char_valid` high for one cycle at E0+154 with `char_out` = 8'h61 (A..H = 0,1,1,0,0,0,0,1).
  - No error flags.
- **Glitch rejection.** Drive `rx_in` low for 4 cycles, then high.
  - FSM returns to IDLE.
  - `char_valid`, `frame_err` and `overrun_err` stay 0.
  - A following 0x44 frame is received correctly.
- **Framing error.** Send 0x28 with the stop bit driven 0, then hold the line low for 3 bit-times, then release it.
  - `frame_err` pulses once at the stop-sample edge.
  - `char_valid` stays 0.
  - No further start is detected until the line goes high.
  - The next 0x41 is received as 8'h41.
- **Overrun.** Hold `char_ready` 0 and send 0x61 followed by 0x62.
  - `char_out` = 8'h61 is held with `char_valid` = 1.
  - `overrun_err` pulses at the second frame's stop sample.
  - Raising `char_ready` yields 0x61 and then `char_valid` = 0.
- **Accept on the load edge.** `char_valid` holds 0x61 and `char_ready` is first asserted in the same cycle as the 0x7A stop-sample edge.
  - `char_out` = 8'h7A with `char_valid` = 1.
  - No `overrun_err`.
- **Reset mid-frame.** Assert `rst` for one cycle during data bit 3 of 0x63.
  - All outputs are 0 on the next edge.
  - No character is emitted for the aborted frame.
  - A subsequent full 0x63 frame yields `char_out` = 8'h63.

Source files
------------

// File: rtl/uart_char_rx.sv
// uart_char_rx: 8N1 serial character receiver feeding the ASCII case converter.
// Oversamples the line at CLKS_PER_BIT clocks per bit. It validates the start
// bit at mid-bit and then samples every following bit one full bit-time later.
// Received characters are presented with a valid/ready handshake.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   rx_in        - asynchronous serial line, idle high
//   char_out     - received character (bit 7 -> converter input A, bit 0 -> H)
//   char_valid   - char_out holds an unconsumed character
//   char_ready   - downstream accepts when char_valid && char_ready
//   frame_err    - one-cycle pulse: stop bit sampled low
//   overrun_err  - one-cycle pulse: completed character dropped, slot busy
module uart_char_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned N  = CLKS_PER_BIT;
  localparam int unsigned H  = N / 2;
  localparam int unsigned CW = $clog2(N);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  // Next-state, bit timing, deserialisation and output-slot handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    char_d  = char_q;
    // A held character is released by an accept; a load below may override.
    valid_d = valid_q && !char_ready;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at mid start bit to reject glitches.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bitn_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // LSB arrives first, so shift in from the top.
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = '0;
          if (bitn_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Slot counts as free if empty or being accepted in this same cycle.
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_s_q) begin
            if (!valid_q || char_ready) begin
              char_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              oerr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Hold off start detection until a held-low line is released.
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign char_out    = char_q;
  assign char_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed plus randomized bench for uart_char_rx. Frames are driven one bit per
// N clocks. The reference model tracks the single output slot and predicts
// the outcome at the stop-sample edge E0+2+H+9N.
module tb_uart_char_rx;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       frame_err;
  logic       overrun_err;

  uart_char_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: the single output slot plus expected error-pulse totals.
  logic       exp_valid;
  logic [7:0] exp_char;
  int         exp_fe = 0;
  int         exp_ov = 0;

  int fe_seen = 0;
  int ov_seen = 0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (overrun_err === 1'b1) ov_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    rx_in = 1'b1;
    repeat (cycles) tick();
  endtask

  // Drive one 8N1 frame and check the outputs around the stop-sample edge.
  // pulse: raise char_ready only for the cycle that ends at the stop-sample edge.
  task automatic send(input logic [7:0] d, input logic stop, input logic rdy, input logic pulse);
    int e0;
    int s;
    e0 = cyc + 1;
    s  = e0 + 2 + H + 9 * N;
    char_ready = rdy;
    if (rdy && exp_valid) exp_valid = 1'b0;
    rx_in = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (N) tick();
    end
    rx_in = stop;
    while (cyc < s - 1) tick();
    chk("pre_valid", char_valid, exp_valid);
    if (exp_valid) chk("pre_char", char_out, exp_char);
    chk("pre_ferr", frame_err, 0);
    chk("pre_oerr", overrun_err, 0);
    if (pulse) char_ready = 1'b1;
    tick();
    if (!stop) begin
      exp_fe++;
      chk("stop_ferr", frame_err, 1);
      chk("stop_oerr", overrun_err, 0);
      chk("stop_valid_fe", char_valid, exp_valid);
    end else if (exp_valid && !char_ready) begin
      exp_ov++;
      chk("stop_oerr", overrun_err, 1);
      chk("stop_ferr", frame_err, 0);
      chk("stop_valid_ov", char_valid, 1);
      chk("stop_char_held", char_out, exp_char);
    end else begin
      exp_valid = 1'b1;
      exp_char  = d;
      chk("stop_valid", char_valid, 1);
      chk("stop_char", char_out, d);
      chk("stop_oerr", overrun_err, 0);
      chk("stop_ferr", frame_err, 0);
    end
    if (pulse) char_ready = 1'b0;
    tick();
    chk("post_ferr", frame_err, 0);
    chk("post_oerr", overrun_err, 0);
    if (char_ready && exp_valid) exp_valid = 1'b0;
    chk("post_valid", char_valid, exp_valid);
    if (exp_valid) chk("post_char", char_out, exp_char);
    while (cyc < e0 - 1 + 10 * N) tick();
    rx_in = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       st;
    logic       rd;
    int         gap;
    logic [7:0] c63;

    rst        = 1'b1;
    rx_in      = 1'b1;
    char_ready = 1'b0;
    exp_valid  = 1'b0;
    exp_char   = 8'h00;
    tick();
    tick();
    chk("rst_char", char_out, 8'h00);
    chk("rst_valid", char_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_oerr", overrun_err, 0);
    rst = 1'b0;
    idle(2 * N);

    // Single character with the sink always ready.
    send(8'h61, 1'b1, 1'b1, 1'b0);
    idle(N);

    // Short low glitch must not start a frame.
    rx_in = 1'b0;
    repeat (4) tick();
    idle(2 * N);
    chk("glitch_valid", char_valid, 0);
    chk("glitch_fe_cnt", fe_seen, exp_fe);
    chk("glitch_ov_cnt", ov_seen, exp_ov);
    send(8'h44, 1'b1, 1'b1, 1'b0);
    idle(N);

    // Framing error followed by a held-low line.
    send(8'h28, 1'b0, 1'b1, 1'b0);
    rx_in = 1'b0;
    repeat (3 * N) tick();
    chk("break_valid", char_valid, 0);
    chk("break_fe_cnt", fe_seen, exp_fe);
    idle(N);
    send(8'h41, 1'b1, 1'b0, 1'b0);
    idle(N);
    chk("hold_valid", char_valid, 1);
    chk("hold_char", char_out, 8'h41);

    // Reset during data bit 3 of 0x63 while 0x41 is still held.
    c63   = 8'h63;
    rx_in = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 3; i++) begin
      rx_in = c63[i];
      repeat (N) tick();
    end
    rx_in = c63[3];
    repeat (H) tick();
    rst   = 1'b1;
    rx_in = 1'b1;
    tick();
    chk("mrst_char", char_out, 8'h00);
    chk("mrst_valid", char_valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_oerr", overrun_err, 0);
    exp_valid = 1'b0;
    exp_char  = 8'h00;
    rst = 1'b0;
    idle(12 * N);
    chk("mrst_no_char", char_valid, 0);
    send(8'h63, 1'b1, 1'b1, 1'b0);
    idle(N);

    // Overrun: second back-to-back frame finds the slot occupied.
    send(8'h61, 1'b1, 1'b0, 1'b0);
    send(8'h62, 1'b1, 1'b0, 1'b0);
    idle(N);
    chk("ovr_held_valid", char_valid, 1);
    chk("ovr_held_char", char_out, 8'h61);
    char_ready = 1'b1;
    tick();
    exp_valid = 1'b0;
    chk("ovr_drained", char_valid, 0);
    char_ready = 1'b0;
    idle(N);

    // Accept in the same cycle as the next load.
    send(8'h61, 1'b1, 1'b0, 1'b0);
    send(8'h7A, 1'b1, 1'b0, 1'b1);
    idle(N);
    chk("aol_char", char_out, 8'h7A);
    char_ready = 1'b1;
    tick();
    exp_valid = 1'b0;
    chk("aol_drained", char_valid, 0);
    char_ready = 1'b0;
    idle(N);

    // Randomized frames, sink readiness and stop-bit errors.
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      rd  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 5) != 0);
      gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send(d, st, rd, 1'b0);
      idle(gap * N);
    end
    char_ready = 1'b1;
    tick();
    exp_valid = 1'b0;
    chk("final_drained", char_valid, 0);
    idle(N);

    chk("total_fe", fe_seen, exp_fe);
    chk("total_ov", ov_seen, exp_ov);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
